// File: rtl/led_pio_sequencer.sv
// Avalon-MM write master that animates an 8-bit LED PIO with walking-one,
// count, blink or static patterns, holding each pattern for a programmable dwell.
module led_pio_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DWELL_W   = 24,
    parameter int DATA_ADDR = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH-1:0]   static_pattern_i,
    input  logic [DWELL_W-1:0] dwell_cycles_i,
    output logic [1:0]         pio_address_o,
    output logic               pio_chipselect_o,
    output logic               pio_write_n_o,
    output logic [31:0]        pio_writedata_o,
    input  logic               pio_waitrequest_i,
    output logic               busy_o,
    output logic [15:0]        step_count_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DWELL = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   pattern_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [15:0]        step_q;
    logic               cs_q;
    logic               write_n_q;
    logic [1:0]         addr_q;
    logic [31:0]        wdata_q;
    logic               busy_q;

    logic [WIDTH-1:0]   init_pattern_d;
    logic [WIDTH-1:0]   next_pattern_d;
    logic [DWELL_W-1:0] dwell_load_d;
    logic               accept_d;

    always_comb begin
        init_pattern_d = '0;
        case (mode_i)
            2'd0:    init_pattern_d = WIDTH'(1);
            2'd1:    init_pattern_d = '0;
            2'd2:    init_pattern_d = '1;
            default: init_pattern_d = static_pattern_i;
        endcase
    end

    always_comb begin
        next_pattern_d = pattern_q;
        case (mode_q)
            2'd0:    next_pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            2'd1:    next_pattern_d = pattern_q + WIDTH'(1);
            2'd2:    next_pattern_d = ~pattern_q;
            default: next_pattern_d = pattern_q;
        endcase
    end

    // A zero dwell would never expire, so it is stretched to one cycle.
    assign dwell_load_d = (dwell_cycles_i == '0) ? DWELL_W'(1) : dwell_cycles_i;

    // Handshake: a write is offered while chipselect=1 and write_n=0 and is
    // consumed on the rising edge where waitrequest=0; the offer never changes
    // before that edge.
    assign accept_d = cs_q && !write_n_q && !pio_waitrequest_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            pattern_q <= '0;
            dwell_q   <= '0;
            step_q    <= '0;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            addr_q    <= 2'd0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        mode_q    <= mode_i;
                        pattern_q <= init_pattern_d;
                        step_q    <= '0;
                        state_q   <= WRITE;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= 2'(DATA_ADDR);
                        wdata_q   <= 32'(init_pattern_d);
                        busy_q    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept_d) begin
                        step_q  <= step_q + 16'd1;
                        dwell_q <= dwell_load_d;
                        if (enable_i) begin
                            state_q   <= DWELL;
                            cs_q      <= 1'b0;
                            write_n_q <= 1'b1;
                            addr_q    <= 2'd0;
                            wdata_q   <= '0;
                        end else begin
                            state_q   <= CLEAR;
                            addr_q    <= 2'(DATA_ADDR);
                            wdata_q   <= '0;
                        end
                    end
                end
                DWELL: begin
                    if (dwell_q != '0) begin
                        dwell_q <= dwell_q - DWELL_W'(1);
                    end
                    if (!enable_i) begin
                        state_q   <= CLEAR;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= 2'(DATA_ADDR);
                        wdata_q   <= '0;
                    end else if (dwell_q == DWELL_W'(1)) begin
                        pattern_q <= next_pattern_d;
                        state_q   <= WRITE;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= 2'(DATA_ADDR);
                        wdata_q   <= 32'(next_pattern_d);
                    end
                end
                CLEAR: begin
                    if (accept_d) begin
                        state_q   <= IDLE;
                        pattern_q <= '0;
                        cs_q      <= 1'b0;
                        write_n_q <= 1'b1;
                        addr_q    <= 2'd0;
                        wdata_q   <= '0;
                        busy_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pio_address_o    = addr_q;
    assign pio_chipselect_o = cs_q;
    assign pio_write_n_o    = write_n_q;
    assign pio_writedata_o  = wdata_q;
    assign busy_o           = busy_q;
    assign step_count_o     = step_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed bench for led_pio_sequencer: expected write data and spacing are
// queued before each run and checked against every accepted bus write.
module tb_led_pio_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [7:0]  static_pattern_i = 8'h00;
    logic [23:0] dwell_cycles_i = 24'd0;
    logic        pio_waitrequest_i = 1'b0;
    logic [1:0]  pio_address_o;
    logic        pio_chipselect_o;
    logic        pio_write_n_o;
    logic [31:0] pio_writedata_o;
    logic        busy_o;
    logic [15:0] step_count_o;
    logic [1:0]  state_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          gap_q[$];
    int          cyc = 0;
    int          last_acc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_ctl = '0;

    led_pio_sequencer dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .mode_i(mode_i),
        .static_pattern_i(static_pattern_i),
        .dwell_cycles_i(dwell_cycles_i),
        .pio_address_o(pio_address_o),
        .pio_chipselect_o(pio_chipselect_o),
        .pio_write_n_o(pio_write_n_o),
        .pio_writedata_o(pio_writedata_o),
        .pio_waitrequest_i(pio_waitrequest_i),
        .busy_o(busy_o),
        .step_count_o(step_count_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_write(input logic [31:0] data, input int gap);
        exp_q.push_back(data);
        gap_q.push_back(gap);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick(1);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        gap_q.delete();
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles && busy_o !== 1'b0; i++) tick(1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_state", 32'(state_o), 32'd0);
        chk("idle_cs", 32'(pio_chipselect_o), 32'd0);
    endtask

    // Scoreboard: an accepted write is visible before the edge that consumes it.
    always @(negedge clk_i) begin
        logic [31:0] e;
        int g;
        cyc++;
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data", pio_writedata_o, prev_data);
                chk("stall_ctl", 32'({pio_address_o, pio_chipselect_o, pio_write_n_o}), 32'(prev_ctl));
            end
            if (pio_chipselect_o && !pio_write_n_o && !pio_waitrequest_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", pio_writedata_o, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    g = gap_q.pop_front();
                    chk("wdata", pio_writedata_o, e);
                    chk("waddr", 32'(pio_address_o), 32'd0);
                    if (g != 0) chk("wgap", 32'(cyc - last_acc), 32'(g));
                end
                last_acc = cyc;
            end
            prev_stall = pio_chipselect_o && !pio_write_n_o && pio_waitrequest_i;
            prev_data  = pio_writedata_o;
            prev_ctl   = {pio_address_o, pio_chipselect_o, pio_write_n_o};
        end
    end

    initial begin
        tick(2);
        chk("rst_cs", 32'(pio_chipselect_o), 32'd0);
        chk("rst_wn", 32'(pio_write_n_o), 32'd1);
        chk("rst_addr", 32'(pio_address_o), 32'd0);
        chk("rst_data", pio_writedata_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_step", 32'(step_count_o), 32'd0);
        reset_i = 1'b0;
        tick(1);

        // Reset asserted while a write is stalled
        mode_i = 2'd3;
        static_pattern_i = 8'h3C;
        pio_waitrequest_i = 1'b1;
        enable_i = 1'b1;
        tick(1);
        chk("t1_cs", 32'(pio_chipselect_o), 32'd1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_data", pio_writedata_o, 32'h3C);
        tick(1);
        reset_i = 1'b1;
        #1;
        chk("t1_rst_cs", 32'(pio_chipselect_o), 32'd0);
        chk("t1_rst_wn", 32'(pio_write_n_o), 32'd1);
        chk("t1_rst_busy", 32'(busy_o), 32'd0);
        chk("t1_rst_step", 32'(step_count_o), 32'd0);
        chk("t1_rst_state", 32'(state_o), 32'd0);
        enable_i = 1'b0;
        pio_waitrequest_i = 1'b0;
        tick(1);
        reset_i = 1'b0;
        tick(1);

        // Walking one, dwell 3
        mode_i = 2'd0;
        dwell_cycles_i = 24'd3;
        push_write(32'h01, 0);
        for (int i = 1; i < 8; i++) push_write(32'(8'h01 << i), 4);
        push_write(32'h01, 4);
        enable_i = 1'b1;
        wait_drain(100);
        chk("t2_step", 32'(step_count_o), 32'd9);
        push_write(32'h00, 2);
        enable_i = 1'b0;
        wait_drain(20);
        wait_idle(10);
        chk("t2_step_after", 32'(step_count_o), 32'd9);

        // Count with dwell 0 through the wrap
        mode_i = 2'd1;
        dwell_cycles_i = 24'd0;
        push_write(32'h00, 0);
        for (int i = 1; i < 256; i++) push_write(32'(i), 2);
        push_write(32'h00, 2);
        enable_i = 1'b1;
        wait_drain(700);
        chk("t3_step", 32'(step_count_o), 32'd257);
        push_write(32'h00, 2);
        enable_i = 1'b0;
        wait_drain(20);
        wait_idle(10);

        // Blink with the first write stalled for five cycles
        mode_i = 2'd2;
        dwell_cycles_i = 24'd2;
        pio_waitrequest_i = 1'b1;
        push_write(32'hFF, 0);
        push_write(32'h00, 3);
        push_write(32'hFF, 3);
        enable_i = 1'b1;
        tick(1);
        chk("t4_stall_data", pio_writedata_o, 32'hFF);
        tick(5);
        chk("t4_stall_step", 32'(step_count_o), 32'd0);
        pio_waitrequest_i = 1'b0;
        wait_drain(50);
        chk("t4_step", 32'(step_count_o), 32'd3);
        push_write(32'h00, 2);
        enable_i = 1'b0;
        wait_drain(20);
        wait_idle(10);

        // Enable dropped while a write is stalled
        mode_i = 2'd0;
        dwell_cycles_i = 24'd1;
        pio_waitrequest_i = 1'b1;
        push_write(32'h01, 0);
        push_write(32'h00, 1);
        enable_i = 1'b1;
        tick(3);
        enable_i = 1'b0;
        tick(2);
        pio_waitrequest_i = 1'b0;
        wait_drain(20);
        wait_idle(10);
        chk("t5_step", 32'(step_count_o), 32'd1);

        // Mode latched at start; change takes effect only after a restart
        mode_i = 2'd3;
        static_pattern_i = 8'hA5;
        dwell_cycles_i = 24'd2;
        push_write(32'hA5, 0);
        for (int i = 0; i < 3; i++) push_write(32'hA5, 3);
        enable_i = 1'b1;
        tick(2);
        mode_i = 2'd1;
        wait_drain(50);
        push_write(32'h00, 2);
        enable_i = 1'b0;
        wait_drain(20);
        wait_idle(10);
        push_write(32'h00, 0);
        push_write(32'h01, 3);
        push_write(32'h02, 3);
        enable_i = 1'b1;
        wait_drain(50);
        chk("t6_step", 32'(step_count_o), 32'd3);
        push_write(32'h00, 2);
        enable_i = 1'b0;
        wait_drain(20);
        wait_idle(10);

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
